hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32I core; sits beside the forwarding unit.

---
 rtl/hazard_ctrl_pkg.sv | 17 +
 rtl/hazard_ctrl_operand_use.sv | 16 +
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller.
// Holds the opcode constants used for operand decode and the sequencing FSM state type.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_operand_use.sv
// Decodes which source registers an RV32I instruction actually reads, from its opcode.
// Unused register fields hold immediate bits and must not raise false hazards.
module hazard_ctrl_operand_use
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  always_comb begin
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes,
// data-memory freeze with timeout abort, and a saturating stall-cycle counter.
//
// state       | meaning
// ST_RUN      | normal flow; branch flush / load-use stall evaluated every cycle
// ST_MEM_WAIT | data access outstanding; pipe frozen until ready or timeout abort
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_id_inst,
  input  logic [31:0]      id_ex_inst,
  input  logic             id_ex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_wb_bubble,
  output logic             dmem_abort,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              err_set;
  logic              freeze;
  logic              pipe_eval;
  logic              uses_rs1, uses_rs2;
  logic              load_use;
  logic [4:0]        rd, rs1, rs2;
  logic              unused_inst;

  assign rd  = id_ex_inst[11:7];
  assign rs1 = if_id_inst[19:15];
  assign rs2 = if_id_inst[24:20];
  assign unused_inst = ^{if_id_inst[31:25], if_id_inst[14:7], id_ex_inst[31:12], id_ex_inst[6:0]};

  hazard_ctrl_operand_use u_operand_use (
    .opcode   (if_id_inst[6:0]),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign load_use = id_ex_memread && (rd != 5'd0) &&
                    ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pipe_freeze   = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_abort    = 1'b0;
    state_nx      = state;
    wait_nx       = wait_cnt;
    err_set       = 1'b0;
    freeze        = 1'b0;
    pipe_eval     = 1'b0;

    case (state)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze   = 1'b1;
          wait_nx  = WAIT_W'(1);
          state_nx = ST_MEM_WAIT;
        end else begin
          pipe_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          pipe_eval = 1'b1;
          wait_nx   = '0;
          state_nx  = ST_RUN;
        end else if (wait_cnt < TIMEOUT_V) begin
          freeze  = 1'b1;
          wait_nx = wait_cnt + WAIT_W'(1);
        end else begin
          // Timeout: the pipe moves again this cycle with the access squashed.
          pipe_eval     = 1'b1;
          dmem_abort    = 1'b1;
          mem_wb_bubble = 1'b1;
          err_set       = 1'b1;
          wait_nx       = '0;
          state_nx      = ST_RUN;
        end
      end
      default: begin
        wait_nx  = '0;
        state_nx = ST_RUN;
      end
    endcase

    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_freeze   = 1'b1;
      mem_wb_bubble = 1'b1;
    end

    // A taken branch squashes the wrong-path consumer, so its load-use stall is dropped.
    if (pipe_eval) begin
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      pipe_freeze   = 1'b0;
      mem_wb_bubble = 1'b0;
      dmem_abort    = 1'b0;
      err_set       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (err_set) begin
        mem_err <= 1'b1;
      end
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CW      = 6;
  localparam int SAT     = (1 << CW) - 1;

  localparam logic [6:0] O_LUI   = 7'b0110111;
  localparam logic [6:0] O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_JAL   = 7'b1101111;
  localparam logic [6:0] O_JALR  = 7'b1100111;
  localparam logic [6:0] O_R     = 7'b0110011;
  localparam logic [6:0] O_S     = 7'b0100011;
  localparam logic [6:0] O_B     = 7'b1100011;
  localparam logic [6:0] O_I     = 7'b0010011;
  localparam logic [6:0] O_LD    = 7'b0000011;

  typedef struct packed {
    logic [8:0]    flags;
    logic [CW-1:0] stall;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   if_id_inst = '0;
  logic [31:0]   id_ex_inst = '0;
  logic          id_ex_memread = 1'b0;
  logic          branch_taken = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
  logic          pipe_freeze, mem_wb_bubble, dmem_abort, mem_err;
  logic [CW-1:0] stall_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [8:0] mon_f;

  // reference model state
  int m_wait = 0;
  bit m_err = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_id_inst    (if_id_inst),
    .id_ex_inst    (id_ex_inst),
    .id_ex_memread (id_ex_memread),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_bubble  (id_ex_bubble),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .pipe_freeze   (pipe_freeze),
    .mem_wb_bubble (mem_wb_bubble),
    .dmem_abort    (dmem_abort),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1, input int r2);
    mk = {7'b0, r2[4:0], r1[4:0], 3'b0, rd[4:0], op};
  endfunction

  function automatic bit hazard(input logic [31:0] a, input logic [31:0] b, input bit rd_ld);
    logic [6:0] op;
    int d, s1, s2;
    bit u1, u2;
    op = a[6:0];
    s1 = int'(a[19:15]);
    s2 = int'(a[24:20]);
    d  = int'(b[11:7]);
    u1 = !(op inside {O_LUI, O_AUIPC, O_JAL});
    u2 = op inside {O_R, O_S, O_B};
    hazard = rd_ld && d != 0 && ((u1 && d == s1) || (u2 && d == s2));
  endfunction

  // Flags order: pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
  // pipe_freeze, mem_wb_bubble, dmem_abort, mem_err.
  task automatic model_step();
    bit pcw = 1, ifw = 1, bub = 0, ff = 0, fe = 0, frz = 0, mwb = 0, ab = 0, go = 1;
    int nw = 0;
    exp_t e;
    if (!rst_n) begin
      m_wait = 0; m_err = 0; m_stall = 0;
    end else begin
      if (m_wait == 0) begin
        if (dmem_req && !dmem_ready) begin frz = 1; go = 0; nw = 1; end
      end else if (dmem_ready) begin
        nw = 0;
      end else if (m_wait < TIMEOUT) begin
        frz = 1; go = 0; nw = m_wait + 1;
      end else begin
        ab = 1; nw = 0;
      end
      if (frz) begin pcw = 0; ifw = 0; mwb = 1; end
      if (ab) mwb = 1;
      if (go) begin
        if (branch_taken) begin ff = 1; fe = 1; end
        else if (hazard(if_id_inst, id_ex_inst, id_ex_memread)) begin pcw = 0; ifw = 0; bub = 1; end
      end
    end
    e.flags = {pcw, ifw, bub, ff, fe, frz, mwb, ab, m_err};
    e.stall = CW'(m_stall);
    sb.push_back(e);
    if (rst_n) begin
      if (ab) m_err = 1;
      if (!pcw && m_stall < SAT) m_stall = m_stall + 1;
      m_wait = nw;
    end
  endtask

  task automatic drive(input bit rst, input logic [31:0] a, input logic [31:0] b, input bit ld,
                       input bit br, input bit req, input bit rdy);
    @(posedge clk);
    #1;
    rst_n = rst; if_id_inst = a; id_ex_inst = b; id_ex_memread = ld;
    branch_taken = br; dmem_req = req; dmem_ready = rdy;
    model_step();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_f = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               pipe_freeze, mem_wb_bubble, dmem_abort, mem_err};
      total++;
      if (mon_f !== mon_e.flags) begin
        bad++;
        $display("FAIL flags cyc=%0d actual=%b required=%b (pcw,ifw,bub,iff,exf,frz,mwb,abt,err)",
                 cyc, mon_f, mon_e.flags);
      end
      total++;
      if (stall_cnt !== mon_e.stall) begin
        bad++;
        $display("FAIL stall_cnt cyc=%0d actual=%0d required=%0d", cyc, stall_cnt, mon_e.stall);
      end
    end
  end

  initial begin
    logic [6:0] ops [9];
    logic [31:0] lw5, use5, nop;
    ops = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_R, O_S, O_B, O_I, O_LD};
    lw5  = mk(O_LD, 5, 1, 0);
    use5 = mk(O_R, 6, 5, 1);
    nop  = mk(O_I, 0, 0, 0);

    drive(0, nop, nop, 0, 0, 0, 0);
    drive(0, use5, lw5, 1, 1, 1, 0);
    drive(1, nop, nop, 0, 0, 0, 0);
    // load-use stall, then bubble clears it
    drive(1, use5, lw5, 1, 0, 0, 0);
    drive(1, use5, nop, 0, 0, 0, 0);
    // operand decode exclusions
    drive(1, mk(O_LUI, 5, 5, 5), lw5, 1, 0, 0, 0);
    drive(1, mk(O_R, 6, 0, 0), mk(O_LD, 0, 1, 0), 1, 0, 0, 0);
    drive(1, mk(O_I, 6, 1, 5), lw5, 1, 0, 0, 0);
    drive(1, mk(O_S, 0, 2, 5), lw5, 1, 0, 0, 0);
    // branch overrides load-use
    drive(1, use5, lw5, 1, 1, 0, 0);
    // memory wait with branch pending, release on 4th
    repeat (3) drive(1, nop, nop, 0, 1, 1, 0);
    drive(1, nop, nop, 0, 1, 1, 1);
    drive(1, nop, nop, 0, 0, 0, 0);
    // timeout abort with a load-use in the abort cycle
    repeat (8) drive(1, nop, nop, 0, 0, 1, 0);
    drive(1, use5, lw5, 1, 0, 1, 0);
    drive(1, nop, nop, 0, 0, 0, 0);
    drive(1, nop, nop, 0, 0, 1, 0);
    drive(1, nop, nop, 0, 0, 0, 1);
    // reset in the middle of a wait
    drive(1, nop, nop, 0, 0, 1, 0);
    drive(1, nop, nop, 0, 0, 1, 0);
    drive(0, use5, lw5, 1, 1, 1, 0);
    drive(0, nop, nop, 0, 0, 1, 0);
    drive(1, nop, nop, 0, 0, 1, 1);
    drive(1, nop, nop, 0, 0, 1, 0);
    drive(1, nop, nop, 0, 0, 0, 1);
    // stall counter saturation
    repeat (SAT + 6) drive(1, use5, lw5, 1, 0, 0, 0);
    drive(1, nop, nop, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      bit req;
      a = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      b = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      req = ($urandom_range(0, 9) < 3);
      drive(($urandom_range(0, 299) != 0), a, b, $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
            req, ($urandom_range(0, 5) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
